// File: rtl/apb_pkg.sv
// Shared types for the APB word-addressed memory slave: FSM states, default
// bus widths and the latched setup-phase transfer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_xfer_t;

endpackage

// File: rtl/apb_mem_slave.sv
// APB slave backed by an inline word array with configurable wait states,
// out-of-range error reporting and a wrapping completed-transfer counter.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic              PWrite,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr,
  output logic [15:0]       XferCnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] memory [0:DEPTH-1];

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  apb_xfer_t         xfer_q, xfer_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [15:0]       xcnt_q, xcnt_d;

  logic              setup_ok;
  logic              latch_in_range;
  logic [DATA_W-1:0] rd_val;
  logic              done;
  logic              commit;

  assign setup_ok       = 32'(PAddr) < 32'(DEPTH);
  assign latch_in_range = 32'(xfer_q.addr) < 32'(DEPTH);
  assign rd_val         = setup_ok ? memory[PAddr[IDX_W-1:0]] : '0;

  assign done    = (state_q != IDLE) && PSel && PEnable && (cnt_q == 4'(WAIT_STATES));
  assign PReady  = done;
  assign PSlvErr = done && !latch_in_range;
  assign PRData  = prdata_q;
  assign XferCnt = xcnt_q;

  // A new setup is accepted from any state, so an unfinished transfer is
  // simply overwritten rather than completed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xfer_d   = xfer_q;
    prdata_d = prdata_q;
    xcnt_d   = xcnt_q;
    commit   = 1'b0;
    if (PSel && !PEnable) begin
      xfer_d.addr  = APB_ADDR_W'(PAddr);
      xfer_d.write = PWrite;
      xfer_d.wdata = APB_DATA_W'(PWData);
      prdata_d     = rd_val;
      cnt_d        = '0;
      state_d      = ACCESS;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ACCESS, WAIT: begin
          if (!PSel) begin
            state_d = IDLE;
          end else if (done) begin
            commit  = xfer_q.write && latch_in_range;
            xcnt_d  = xcnt_q + 16'd1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xfer_q   <= '0;
      prdata_q <= '0;
      xcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      prdata_q <= prdata_d;
      xcnt_q   <= xcnt_d;
    end
  end

  // Storage is deliberately not reset; Rst still blocks a write on its edge.
  always_ff @(posedge clk) begin
    if (commit && !Rst) begin
      memory[xfer_q.addr[IDX_W-1:0]] <= DATA_W'(xfer_q.wdata);
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one zero-wait and one 3-wait instance.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] paddr   [2];
  logic        pwrite  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [15:0] xcnt    [2];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) mem (
    .clk(clk), .Rst(Rst), .PAddr(paddr[0]), .PWrite(pwrite[0]), .PSel(psel[0]),
    .PEnable(penable[0]), .PWData(pwdata[0]), .PRData(prdata[0]), .PReady(pready[0]),
    .PSlvErr(pslverr[0]), .XferCnt(xcnt[0])
  );

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) mem3 (
    .clk(clk), .Rst(Rst), .PAddr(paddr[1]), .PWrite(pwrite[1]), .PSel(psel[1]),
    .PEnable(penable[1]), .PWData(pwdata[1]), .PRData(prdata[1]), .PReady(pready[1]),
    .PSlvErr(pslverr[1]), .XferCnt(xcnt[1])
  );

  // Called at posedge+1 with the bus idle; returns at posedge+1 after completion.
  task automatic xfer(input int w, input logic [15:0] a, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    logic ok;
    ok = 1'b0; rd = '0; err = 1'b0; waits = 0;
    psel[w] = 1'b1; penable[w] = 1'b0; paddr[w] = a; pwrite[w] = wr; pwdata[w] = wd;
    @(posedge clk); #1 penable[w] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready[w] === 1'b1) begin
        ok = 1'b1; rd = prdata[w]; err = pslverr[w];
        break;
      end
      waits++;
    end
    @(posedge clk); #1 psel[w] = 1'b0; penable[w] = 1'b0;
    tot_cnt++;
    if (ok !== 1'b1) $display("FAIL xfer_timeout dut%0d addr %h: PReady never seen, required within 40 cycles", w, a);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      paddr[w] = '0; pwrite[w] = 1'b0; psel[w] = 1'b0; penable[w] = 1'b0; pwdata[w] = '0;
    end
    #1;
    tot_cnt++; if (pready[0] !== 1'b0) $display("FAIL rst_pready got %b exp 0", pready[0]); else pass_cnt++;
    tot_cnt++; if (pslverr[0] !== 1'b0) $display("FAIL rst_pslverr got %b exp 0", pslverr[0]); else pass_cnt++;
    tot_cnt++; if (prdata[0] !== 32'h0) $display("FAIL rst_prdata got %h exp 0", prdata[0]); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'h0) $display("FAIL rst_xfercnt got %h exp 0", xcnt[0]); else pass_cnt++;
    tot_cnt++; if (xcnt[1] !== 16'h0) $display("FAIL rst_xfercnt3 got %h exp 0", xcnt[1]); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 16'h0050, 1'b1, 32'h0000_0050, rd, err, waits);
    tot_cnt++; if (waits !== 0) $display("FAIL wr_latency got %0d waits exp 0", waits); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL wr_pslverr got %b exp 0", err); else pass_cnt++;
    tot_cnt++; if (mem.memory[8'h50] !== 32'h50) $display("FAIL wr_mem50 got %h exp 00000050", mem.memory[8'h50]); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'd1) $display("FAIL wr_xfercnt got %0d exp 1", xcnt[0]); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 16'h0000, 1'b1, 32'h0000_000A, rd, err, waits);
    xfer(0, 16'h0100, 1'b1, 32'h0000_1234, rd, err, waits);
    tot_cnt++; if (err !== 1'b1) $display("FAIL oor_wr_err got %b exp 1", err); else pass_cnt++;
    tot_cnt++; if (mem.memory[8'h00] !== 32'hA) $display("FAIL oor_wr_alias got %h exp 0000000a", mem.memory[8'h00]); else pass_cnt++;
    xfer(0, 16'h0100, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (err !== 1'b1) $display("FAIL oor_rd_err got %b exp 1", err); else pass_cnt++;
    tot_cnt++; if (rd !== 32'h0) $display("FAIL oor_rd_data got %h exp 0", rd); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'd4) $display("FAIL oor_xfercnt got %0d exp 4", xcnt[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 16'h0040, 1'b1, 32'h0000_0077, rd, err, waits);
    xfer(0, 16'h0030, 1'b1, 32'hAAAA_0030, rd, err, waits);
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 16'h0030; pwrite[0] = 1'b1; pwdata[0] = 32'h0000_0055;
    @(posedge clk); #1 penable[0] = 1'b1;
    #2;
    tot_cnt++; if (pready[0] !== 1'b1) $display("FAIL rmid_pre_ready got %b exp 1", pready[0]); else pass_cnt++;
    Rst = 1'b1;
    #1;
    tot_cnt++; if (pready[0] !== 1'b0) $display("FAIL rmid_pready got %b exp 0", pready[0]); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'h0) $display("FAIL rmid_xfercnt got %h exp 0", xcnt[0]); else pass_cnt++;
    tot_cnt++; if (prdata[0] !== 32'h0) $display("FAIL rmid_prdata got %h exp 0", prdata[0]); else pass_cnt++;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; Rst = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (mem.memory[8'h30] !== 32'hAAAA_0030) $display("FAIL rmid_mem30 got %h exp aaaa0030", mem.memory[8'h30]); else pass_cnt++;
    xfer(0, 16'h0040, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (rd !== 32'h77) $display("FAIL rmid_rd40 got %h exp 00000077", rd); else pass_cnt++;
    xfer(0, 16'h0030, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (rd !== 32'hAAAA_0030) $display("FAIL rmid_rd30 got %h exp aaaa0030", rd); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'd2) $display("FAIL rmid_xfercnt2 got %0d exp 2", xcnt[0]); else pass_cnt++;
  endtask

  task automatic test_stray_enable();
    logic [31:0] rd; logic err; int waits; int seen;
    seen = 0;
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 16'h0050; pwrite[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready[0] !== 1'b0) seen++;
    end
    @(posedge clk); #1 psel[0] = 1'b0; penable[0] = 1'b0;
    tot_cnt++; if (seen !== 0) $display("FAIL stray_pready got %0d ready cycles exp 0", seen); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'd2) $display("FAIL stray_xfercnt got %0d exp 2", xcnt[0]); else pass_cnt++;
    xfer(0, 16'h0050, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (rd !== 32'h50) $display("FAIL stray_next_rd got %h exp 00000050", rd); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int waits;
    xfer(1, 16'h0010, 1'b1, 32'hDEAD_BEEF, rd, err, waits);
    tot_cnt++; if (waits !== 3) $display("FAIL ws_wr_waits got %0d exp 3", waits); else pass_cnt++;
    tot_cnt++; if (mem3.memory[8'h10] !== 32'hDEAD_BEEF) $display("FAIL ws_mem10 got %h exp deadbeef", mem3.memory[8'h10]); else pass_cnt++;
    xfer(1, 16'h0010, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (waits !== 3) $display("FAIL ws_rd_waits got %0d exp 3", waits); else pass_cnt++;
    tot_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ws_rd_data got %h exp deadbeef", rd); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL ws_rd_err got %b exp 0", err); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int waits;
    xfer(1, 16'h0020, 1'b1, 32'h1111_1111, rd, err, waits);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h0020; pwrite[1] = 1'b1; pwdata[1] = 32'h2222_2222;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(negedge clk);
    tot_cnt++; if (pready[1] !== 1'b0) $display("FAIL abort_pready got %b exp 0", pready[1]); else pass_cnt++;
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (mem3.memory[8'h20] !== 32'h1111_1111) $display("FAIL abort_mem20 got %h exp 11111111", mem3.memory[8'h20]); else pass_cnt++;
    tot_cnt++; if (xcnt[1] !== 16'd3) $display("FAIL abort_xfercnt got %0d exp 3", xcnt[1]); else pass_cnt++;
    xfer(1, 16'h0020, 1'b0, 32'h0, rd, err, waits);
    tot_cnt++; if (rd !== 32'h1111_1111) $display("FAIL abort_next_rd got %h exp 11111111", rd); else pass_cnt++;
    tot_cnt++; if (xcnt[1] !== 16'd4) $display("FAIL abort_next_cnt got %0d exp 4", xcnt[1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int waits; int c0; int wsum;
    force mem.xcnt_q = 16'hFFFD;
    #1 release mem.xcnt_q;
    #1;
    tot_cnt++; if (xcnt[0] !== 16'hFFFD) $display("FAIL b2b_preset got %h exp fffd", xcnt[0]); else pass_cnt++;
    @(posedge clk); #1;
    c0 = cyc; wsum = 0;
    for (int i = 0; i < 3; i++) begin
      xfer(0, 16'h0050, 1'b0, 32'h0, rd, err, waits);
      wsum += waits;
    end
    tot_cnt++; if (xcnt[0] !== 16'h0000) $display("FAIL b2b_wrap got %h exp 0000", xcnt[0]); else pass_cnt++;
    xfer(0, 16'h0040, 1'b0, 32'h0, rd, err, waits);
    wsum += waits;
    tot_cnt++; if (cyc - c0 !== 8) $display("FAIL b2b_cadence got %0d cycles exp 8", cyc - c0); else pass_cnt++;
    tot_cnt++; if (wsum !== 0) $display("FAIL b2b_waits got %0d exp 0", wsum); else pass_cnt++;
    tot_cnt++; if (rd !== 32'h77) $display("FAIL b2b_last_rd got %h exp 00000077", rd); else pass_cnt++;
    tot_cnt++; if (xcnt[0] !== 16'h0001) $display("FAIL b2b_after_wrap got %h exp 0001", xcnt[0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_reset_mid();
    test_stray_enable();
    test_wait_states();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB slave memory that consumes the PAddr/PWrite/PSel/PWData/PEnable transfers produced by the bus driver in the test bench and the master-side write/read tasks. It decodes APB setup/access phases, inserts a configurable number of wait states, stores write data in a word-indexed array and returns read data with PReady/PSlvErr. It is instantiated as `mem` under `top`, so benches can check `top.mem.memory[addr]` directly.

## Interface

Parameters:
- ADDR_W, 16, PAddr width
- DATA_W, 32, PWData/PRData width
- DEPTH, 256, number of words; valid addresses are 0..DEPTH-1
- WAIT_STATES, 0, extra access cycles before PReady (0..15)

Ports:
- clk  in  1  bus clock; all state updates on the rising edge
- Rst  in  1  reset, asynchronous, active-high
- PAddr  in  ADDR_W  word address (no byte offset)
- PWrite  in  1  1 = write, 0 = read
- PSel  in  1  slave select
- PEnable  in  1  access phase
- PWData  in  DATA_W  write data
- PRData  out  DATA_W  read data, valid while PReady=1 on a read
- PReady  out  1  transfer completes this cycle
- PSlvErr  out  1  address out of range; valid only with PReady=1
- XferCnt  out  16  count of completed transfers (OK or error), wraps 0xFFFF→0

## Operation

- State machine with three states (IDLE, ACCESS, WAIT) and a 4-bit wait counter.
- IDLE: an edge that samples PSel=1, PEnable=0 is a setup phase. It latches PAddr/PWrite/PWData and loads PRData with memory[PAddr] (0 if out of range), clears the counter and moves to ACCESS. PEnable=1 without a preceding setup is ignored and the state stays IDLE.
- ACCESS/WAIT with PSel=1, PEnable=1: if the counter equals WAIT_STATES, PReady=1. At that edge the transfer completes: a write commits to memory, XferCnt increments and the state moves to IDLE. Otherwise the counter increments and the state moves to WAIT.
- ACCESS/WAIT with PSel=0: the transfer aborts. The state moves to IDLE with no write and no count.
- ACCESS/WAIT with PSel=1, PEnable=0 (new setup before completion): the old transfer aborts and the new one is latched as a setup, which re-enters ACCESS.
- Range check: latched address ≥ DEPTH gives PSlvErr=1 together with PReady. A write to an out-of-range address is dropped; a read returns PRData=0.
- PReady and PSlvErr are combinational from state, counter and PEnable. PRData is registered.
- The memory array `memory[0:DEPTH-1]` is not cleared by reset.

## Timing

- Reset values: PRData=0, PReady=0, PSlvErr=0, XferCnt=0, state=IDLE, counter=0.
- Rst asserted mid-transfer: immediate return to IDLE. The pending write is dropped and memory keeps its prior contents.
- Timeline with WAIT_STATES=0: setup in cycle N, access in cycle N+1 with PReady=1, write visible in memory after the N+1 edge. A transfer takes 2 cycles minimum.
- With WAIT_STATES=W: PReady rises in cycle N+1+W. The master must hold PSel/PEnable for that long.
- Back-to-back: a setup in the cycle right after completion is accepted, giving a 2-cycle transfer cadence.
- Read after write to the same address: the read setup must fall on or after the write's completion edge. That read returns the new value.
- PReady is 0 in every cycle where PEnable=0 or the state is IDLE.

## Structure

- Package `apb_pkg` holds:
  - the state enum (IDLE, ACCESS, WAIT),
  - localparams for the default ADDR_W and DATA_W,
  - the transfer struct (addr, write, wdata) used for the latched setup.
- No sub-module. Storage stays inline as `memory` so benches can reach it hierarchically.

## Test plan

- Reset then write 0x50→addr 0x50 (WAIT_STATES=0), PEnable held 1 cycle → PReady=1 in the access cycle, PSlvErr=0, `memory[0x50]`=0x50, XferCnt=1.
- Write 0xDEADBEEF→0x10, then read 0x10 with WAIT_STATES=3 → PReady low for 3 access cycles, then high with PRData=0xDEADBEEF.
- Write 0x1234→addr 0x100 (DEPTH=256) → PReady=1 with PSlvErr=1 and no memory change. A read of 0x100 returns PRData=0 with PSlvErr=1. XferCnt increments for both.
- PSel dropped during a wait state of a write to 0x20 → no write (`memory[0x20]` unchanged), XferCnt unchanged, next transfer completes normally.
- Rst pulsed in the access cycle of a write to 0x30 → outputs return to 0 asynchronously and `memory[0x30]` is unchanged. A preloaded `memory[0x40]`=0x77 survives and reads back 0x77.
- 65536 back-to-back reads → XferCnt wraps to 0. A stray PEnable=1 with no setup → no PReady, no count.
